// File: rtl/bt_cmd_decoder.sv
// Command decoder behind the Bluetooth UART receiver. A byte is accepted once it
// changes and holds steady; ASCII drive commands set motor directions and speed.
module bt_cmd_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       flag_in,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] speed,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       timeout,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE} state_t;

  localparam logic [7:0]  STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [27:0] WD_LAST  = 28'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  M_STOP   = 2'b00;
  localparam logic [1:0]  M_FWD    = 2'b01;
  localparam logic [1:0]  M_REV    = 2'b10;

  state_t      state_q;
  logic [7:0]  last_data_q;
  logic [7:0]  cand_q;
  logic [7:0]  cnt_q;
  logic [27:0] wd_q;
  logic        cmd_valid_q;
  logic [2:0]  cmd_code_q;
  logic [3:0]  speed_q;
  logic [1:0]  motor_l_q;
  logic [1:0]  motor_r_q;
  logic        timeout_q;
  logic        err_q;

  logic        dec_ok;
  logic        dec_spd;
  logic [2:0]  dec_code;
  logic [1:0]  dec_l;
  logic [1:0]  dec_r;

  // Classify the settled candidate; a low flag means 0x00/0x30, which is STOP.
  always_comb begin
    dec_ok   = 1'b1;
    dec_spd  = 1'b0;
    dec_code = 3'd0;
    dec_l    = M_STOP;
    dec_r    = M_STOP;
    if (flag_in) begin
      case (cand_q)
        8'h53: dec_code = 3'd0;
        8'h46: begin dec_code = 3'd1; dec_l = M_FWD; dec_r = M_FWD; end
        8'h42: begin dec_code = 3'd2; dec_l = M_REV; dec_r = M_REV; end
        8'h4C: begin dec_code = 3'd3; dec_l = M_REV; dec_r = M_FWD; end
        8'h52: begin dec_code = 3'd4; dec_l = M_FWD; dec_r = M_REV; end
        default: begin
          if (cand_q >= 8'h31 && cand_q <= 8'h39) begin
            dec_spd  = 1'b1;
            dec_code = 3'd5;
          end else begin
            dec_ok = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_data_q <= 8'h00;
      cand_q      <= 8'h00;
      cnt_q       <= 8'd0;
      wd_q        <= 28'd0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      speed_q     <= 4'd5;
      motor_l_q   <= M_STOP;
      motor_r_q   <= M_STOP;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (data_in != last_data_q) begin
            cand_q  <= data_in;
            cnt_q   <= 8'd1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          // Returning to the already-applied byte is a glitch, not a new command.
          if (data_in == last_data_q) begin
            state_q <= IDLE;
          end else if (data_in != cand_q) begin
            cand_q <= data_in;
            cnt_q  <= 8'd1;
          end else if (cnt_q == STABLE_C) begin
            state_q <= DECODE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DECODE: begin
          last_data_q <= cand_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A recognised command preempts a watchdog expiry in the same cycle.
      if (state_q == DECODE && dec_ok) begin
        cmd_valid_q <= 1'b1;
        cmd_code_q  <= dec_code;
        timeout_q   <= 1'b0;
        wd_q        <= 28'd0;
        if (dec_spd) begin
          speed_q <= cand_q[3:0];
        end else begin
          motor_l_q <= dec_l;
          motor_r_q <= dec_r;
        end
      end else begin
        if (state_q == DECODE) begin
          err_q <= 1'b1;
        end
        if (motor_l_q != M_STOP || motor_r_q != M_STOP) begin
          if (wd_q == WD_LAST) begin
            motor_l_q <= M_STOP;
            motor_r_q <= M_STOP;
            timeout_q <= 1'b1;
            wd_q      <= 28'd0;
          end else begin
            wd_q <= wd_q + 28'd1;
          end
        end else begin
          wd_q <= 28'd0;
        end
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign speed     = speed_q;
  assign motor_l   = motor_l_q;
  assign motor_r   = motor_r_q;
  assign timeout   = timeout_q;
  assign err       = err_q;

endmodule

// File: doc/bt_cmd_decoder.md
# bt_cmd_decoder

Command decoder directly downstream of the Bluetooth UART receiver. It consumes the receiver's held byte (`data_in`) and its nonzero flag (`flag_in`). It accepts a byte as a new command once the byte has changed and stayed stable for a programmable number of cycles. It then decodes ASCII drive commands into left/right motor direction codes and a speed level, and stops the motors through a watchdog if no command arrives for a programmable time.

## Interface
- `STABLE_CYCLES`, default 16: consecutive cycles a changed byte must hold before it is decoded. Range 1–255.
- `TIMEOUT_CYCLES`, default 200_000_000: watchdog period in clk cycles (2 s at 100 MHz). Must be < 2^28.
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `data_in`, input, 8: byte held by the UART receiver.
- `flag_in`, input, 1: high when `data_in` is neither 0x00 nor 0x30.
- `cmd_valid`, output, 1: one-cycle pulse when a recognised command has been applied.
- `cmd_code`, output, 3: last applied command: 0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT, 5 SPEED.
- `speed`, output, 4: current speed level, 1–9.
- `motor_l`, output, 2: left motor: 00 stop, 01 forward, 10 reverse.
- `motor_r`, output, 2: right motor, same encoding as `motor_l`.
- `timeout`, output, 1: sticky; high after a watchdog stop until the next `cmd_valid`.
- `err`, output, 1: one-cycle pulse when a stable byte is not a recognised command.

## Operation
- Internal registers:
  - `last_data[7:0]`, reset 0x00.
  - `cand[7:0]`.
  - `cnt[7:0]`.
  - `wd[27:0]`.
  - FSM states IDLE, SETTLE, DECODE.
- IDLE: if `data_in` != `last_data`, set `cand` <= `data_in`, `cnt` <= 1, go to SETTLE.
- SETTLE, evaluated in priority order:
  1. `data_in` == `last_data`: go to IDLE, no decode (glitch rejected).
  2. `data_in` != `cand`: set `cand` <= `data_in`, `cnt` <= 1.
  3. `cnt` == `STABLE_CYCLES`: go to DECODE.
  4. Otherwise `cnt` <= `cnt` + 1.
- DECODE is a single cycle. It sets `last_data` <= `cand`, classifies `cand`, applies the result, and returns to IDLE.
  - `flag_in` low (0x00 or 0x30): STOP. Motors 00/00, code 0.
  - 0x53 'S': STOP, same as above.
  - 0x46 'F': l=01, r=01, code 1.
  - 0x42 'B': l=10, r=10, code 2.
  - 0x4C 'L': l=10, r=01, code 3.
  - 0x52 'R': l=01, r=10, code 4.
  - 0x31–0x39: `speed` <= `cand`[3:0], code 5, motors unchanged.
  - Any other byte: `err` pulses; all other outputs unchanged; no `cmd_valid`.
- Every recognised command pulses `cmd_valid`, clears `timeout` and clears `wd`.
- Watchdog behaviour:
  - `wd` increments each cycle while `motor_l` or `motor_r` is nonzero.
  - `wd` holds at 0 while both motors are stopped.
  - When `wd` == `TIMEOUT_CYCLES`-1, the next edge forces motors to 00/00, sets `timeout`=1, sets `wd`=0, and leaves `cmd_code` unchanged.
- Simultaneous DECODE and watchdog expiry: DECODE wins and the watchdog does not fire.
- Reset values: `cmd_valid`=0, `cmd_code`=0, `speed`=5, `motor_l`=`motor_r`=00, `timeout`=0, `err`=0, FSM in IDLE, `cnt`=0, `wd`=0, `last_data`=0x00.
- Reset mid-SETTLE discards the candidate. After reset, a byte still held by the receiver is re-decoded if it differs from 0x00.

## Timing
- Edge t0 is the first edge that samples a new `data_in` value.
- Latency:
  - Edge t0+STABLE_CYCLES enters DECODE.
  - Outputs update at edge t0+STABLE_CYCLES+1.
  - `cmd_valid`/`err` are high for exactly that one cycle.
- Any change of `data_in` during SETTLE restarts the count from that edge.
- The same byte re-received is not re-decoded, because `data_in` does not change.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `TIMEOUT_CYCLES`=1000.
- Reset: assert `reset` asynchronously mid-cycle -> immediately `motor_l`=`motor_r`=00, `speed`=5, `cmd_code`=0, `cmd_valid`=`err`=`timeout`=0.
- Forward: hold `data_in`=0x46, `flag_in`=1 from edge t0 -> `cmd_valid` high for one cycle after edge t0+5, `motor_l`=`motor_r`=01, `cmd_code`=1; no further pulses while the byte is held.
- Glitch: `data_in`=0x46 for 2 cycles, then 0x00 -> no `cmd_valid`, no `err`, outputs unchanged. Separately, 0x42 for 2 cycles then 0x52 held -> a single decode of RIGHT at 5 edges after the switch.
- Speed and error: 0x37 -> `speed`=7, `cmd_code`=5, motors unchanged, `cmd_valid` pulse. Then 0x41 -> one-cycle `err`, no `cmd_valid`, `speed` stays 7.
- Watchdog: apply 'L', then hold it -> 1000 cycles after the `cmd_valid` cycle, motors become 00/00 and `timeout`=1. Then apply 0x30 (`flag_in`=0) -> `cmd_valid`, `cmd_code`=0, `timeout`=0.
- Reset mid-SETTLE: 0x46 held, `reset` pulsed at t0+2 -> no decode before reset; after release, 'F' is decoded 5 edges after the first post-reset edge.
